brcomp_seq: RTL
===============

# brcomp_seq

Sequential, parametrised branch comparator for the execute stage. It takes two XLEN-bit operands and a branch funct3 through a valid/ready handshake, and compares them MSB-first, SLICE bits per cycle. It returns registered less/equal flags, the resolved branch-taken decision and an illegal-funct3 flag. It succeeds the single-cycle combinational comparator where XLEN grows or timing closure requires the compare to be spread over several cycles.

## Interface
Parameters:
- XLEN, 32, operand width
- SLICE, 8, bits compared per cycle; XLEN % SLICE must be 0, otherwise elaboration error
- EARLY_EXIT, 0, 1 = finish as soon as a slice differs; 0 = fixed latency

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_flush  in  1  synchronous abort of any in-flight compare
- i_valid  in  1  operands valid
- o_ready  out  1  block can accept operands
- i_rs1_data  in  XLEN  operand A
- i_rs2_data  in  XLEN  operand B
- i_funct3  in  3  branch funct3
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_br_less  out  1  A < B (signed or unsigned per funct3[1])
- o_br_equal  out  1  A == B
- o_br_taken  out  1  branch condition true
- o_illegal  out  1  funct3 is 010 or 011

## Operation
- funct3 decode:
  - 000 BEQ: taken = equal
  - 001 BNE: taken = !equal
  - 100 BLT: taken = less
  - 101 BGE: taken = !less
  - 110 BLTU: taken = less
  - 111 BGEU: taken = !less
  - 010 / 011: illegal = 1, taken = 0; less and equal are still computed (signed)
- Unsigned mode: funct3[1] = 1. Signed mode: invert bit XLEN-1 of both operands, then compare unsigned.
- FSM states:
  - IDLE: o_ready = 1. On i_valid && o_ready, latch the operands and funct3, set eq_acc = 1, lt_acc = 0, idx = NSLICE-1 (NSLICE = XLEN/SLICE), go to BUSY.
  - BUSY: each cycle compare slice idx.
    - If eq_acc is set and the slices differ: eq_acc = 0 and lt_acc = slice_lt.
    - Then decrement idx.
    - Go to DONE after slice 0 is processed.
    - With EARLY_EXIT = 1, also go to DONE in the cycle a difference is found.
  - DONE: o_valid = 1 and the outputs are held stable. On i_ready, go to IDLE.
- Once eq_acc clears, later slices do not change lt_acc.
- i_flush in any state: next state is IDLE and o_valid = 0. Flush takes priority over every handshake in the same cycle.
- i_valid is ignored outside IDLE, so there is no overlap between compares.
- Reset (i_rst_n = 0 at an edge): state IDLE, o_valid = 0, and all result outputs = 0. o_ready = 1 from the first cycle after reset. A compare in progress when reset hits is discarded.

## Timing
- Operands are accepted on edge T0. With EARLY_EXIT = 0, o_valid is first high in the cycle after edge T0 + NSLICE.
- With EARLY_EXIT = 1, o_valid is first high after edge T0 + k + 1, where k counts slices from the top (0-based) up to the first differing slice. Equal operands always take NSLICE cycles.
- SLICE == XLEN: one-cycle compare, valid in the cycle after T0 + 1.
- Best-case throughput, with i_ready held high: one compare per NSLICE + 2 cycles (DONE and IDLE each last one cycle).
- All outputs are registered. Nothing is combinational from inputs to outputs except that o_ready is a decode of the state.
- i_ready low in DONE: the result and o_valid hold indefinitely.

## Structure
- brcomp_pkg:
  - funct3 localparams (F3_BEQ … F3_BGEU)
  - state enum (IDLE, BUSY, DONE)
- Sub-module brcomp_slice: combinational, SLICE-bit inputs a and b; outputs lt and eq.
- Top level holds the FSM, operand registers, idx counter and accumulators.
- idx width: $clog2(NSLICE), minimum 1.

## Test plan
All cases use XLEN = 32, SLICE = 8, NSLICE = 4.
- rs1 = 0xFFFFFFFF, rs2 = 0x00000001, funct3 = 100 → o_valid 4 cycles after accept; less = 1, equal = 0, taken = 1, illegal = 0.
- Same operands, funct3 = 110 → less = 0, taken = 0. Same operands, funct3 = 111 → taken = 1.
- rs1 = rs2 = 0x12345678: funct3 = 000 → equal = 1, taken = 1; funct3 = 001 → taken = 0.
- Hold i_ready = 0 for 3 cycles in DONE while pulsing i_valid with new operands → outputs unchanged, o_ready = 0, the new request is not accepted. Raise i_ready → IDLE next cycle.
- i_flush in the 2nd BUSY cycle → IDLE next cycle, o_valid never rises, o_ready = 1. Repeat with i_rst_n = 0 mid-BUSY → same result, all outputs 0.
- funct3 = 010 → illegal = 1, taken = 0. With EARLY_EXIT = 1: rs1 = 0x80000000, rs2 = 0x00000000, funct3 = 100 → o_valid 1 cycle after accept, less = 1.

Source files
------------

// File: rtl/brcomp_pkg.sv
// Shared definitions for the sequential branch comparator: funct3 codes,
// FSM state encoding and the funct3 decode helpers.
package brcomp_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic f3_illegal(input logic [2:0] f3);
      return f3[2:1] == 2'b01;
   endfunction

   // Illegal codes 010/011 have funct3[1] set but still compare signed.
   function automatic logic f3_unsigned(input logic [2:0] f3);
      return f3[2] & f3[1];
   endfunction

   function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
      logic taken;
      taken = 1'b0;
      case (f3)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = !eq;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = !lt;
         F3_BLTU: taken = lt;
         F3_BGEU: taken = !lt;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/brcomp_slice.sv
// Unsigned compare of one SLICE-bit chunk of the operands.
module brcomp_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic             lt,
   output logic             eq
);

   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/brcomp_seq.sv
// Multi-cycle branch comparator: walks the operands MSB-first one slice per
// cycle behind a valid/ready handshake and returns registered branch flags.
module brcomp_seq
   import brcomp_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SLICE      = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [2:0]      i_funct3,
   output logic            o_valid,
   input  logic            i_ready,
   output logic            o_br_less,
   output logic            o_br_equal,
   output logic            o_br_taken,
   output logic            o_illegal
);

   localparam int NSLICE = XLEN / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if (XLEN % SLICE != 0) begin : g_bad_slice
         $error("brcomp_seq: XLEN must be a multiple of SLICE");
      end
   endgenerate

   state_t            state_reg;
   logic [XLEN-1:0]   rs1_reg;
   logic [XLEN-1:0]   rs2_reg;
   logic [2:0]        f3_reg;
   logic [IW-1:0]     idx_reg;
   logic              eq_acc_reg;
   logic              lt_acc_reg;

   logic [XLEN-1:0]   rs1_in;
   logic [XLEN-1:0]   rs2_in;
   logic [SLICE-1:0]  a_sl [NSLICE];
   logic [SLICE-1:0]  b_sl [NSLICE];
   logic              sl_lt;
   logic              sl_eq;
   logic              eq_next;
   logic              lt_next;
   logic              finish;

   // Signed compare becomes unsigned once both sign bits are flipped.
   always_comb begin
      rs1_in = i_rs1_data;
      rs2_in = i_rs2_data;
      rs1_in[XLEN-1] = i_rs1_data[XLEN-1] ^ !f3_unsigned(i_funct3);
      rs2_in[XLEN-1] = i_rs2_data[XLEN-1] ^ !f3_unsigned(i_funct3);
   end

   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_sl
      assign a_sl[gi] = rs1_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = rs2_reg[gi*SLICE +: SLICE];
   end

   brcomp_slice #(.SLICE(SLICE)) u_slice (
      .a  (a_sl[idx_reg]),
      .b  (b_sl[idx_reg]),
      .lt (sl_lt),
      .eq (sl_eq)
   );

   // The first differing slice decides; lower slices are ignored afterwards.
   always_comb begin
      eq_next = eq_acc_reg & sl_eq;
      lt_next = (eq_acc_reg && !sl_eq) ? sl_lt : lt_acc_reg;
      finish  = (idx_reg == '0) || ((EARLY_EXIT != 0) && eq_acc_reg && !sl_eq);
   end

   assign o_ready = (state_reg == IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg  <= IDLE;
         rs1_reg    <= '0;
         rs2_reg    <= '0;
         f3_reg     <= '0;
         idx_reg    <= '0;
         eq_acc_reg <= 1'b0;
         lt_acc_reg <= 1'b0;
         o_valid    <= 1'b0;
         o_br_less  <= 1'b0;
         o_br_equal <= 1'b0;
         o_br_taken <= 1'b0;
         o_illegal  <= 1'b0;
      end else if (i_flush) begin
         state_reg <= IDLE;
         o_valid   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  rs1_reg    <= rs1_in;
                  rs2_reg    <= rs2_in;
                  f3_reg     <= i_funct3;
                  eq_acc_reg <= 1'b1;
                  lt_acc_reg <= 1'b0;
                  idx_reg    <= IW'(NSLICE - 1);
                  state_reg  <= BUSY;
               end
            end
            BUSY: begin
               eq_acc_reg <= eq_next;
               lt_acc_reg <= lt_next;
               idx_reg    <= idx_reg - 1'b1;
               if (finish) begin
                  state_reg  <= DONE;
                  o_valid    <= 1'b1;
                  o_br_less  <= lt_next;
                  o_br_equal <= eq_next;
                  o_br_taken <= f3_taken(f3_reg, eq_next, lt_next);
                  o_illegal  <= f3_illegal(f3_reg);
               end
            end
            DONE: begin
               if (i_ready) begin
                  state_reg <= IDLE;
                  o_valid   <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
